spi_fsm: RTL and testbench
==========================

SPI_FSM -- requirements
Module: spi_fsm

Interface
REQ-001 Parameter: WIDTH, 8, bits per SPI byte (address+R/W byte and data byte); must match the shift register width.
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: resetN  input  1  reset, asynchronous, active-low.
REQ-004 Port: csN  input  1  conditioned SPI chip select, active-low, synchronous to clk.
REQ-005 Port: sclkPosEdge  input  1  one-clk pulse marking an SCLK rising edge.
REQ-006 Port: sclkNegEdge  input  1  one-clk pulse marking an SCLK falling edge.
REQ-007 Port: rwBit  input  1  shift register parallelDataOut[0]; 1 = read, 0 = write.
REQ-008 Port: addrLatchEn  output  1  loads the address latch from the shift register.
REQ-009 Port: memWriteEn  output  1  data memory write strobe.
REQ-010 Port: srParallelLoad  output  1  drives the shift register parallelLoad.
REQ-011 Port: misoBufEn  output  1  enables the MISO tri-state buffer.
REQ-012 Port: busy  output  1  high in every state except IDLE.

Function
REQ-013 States: IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_GET, WRITE_STORE, DONE.
REQ-014 Outputs are Moore-decoded from state only; no output depends combinationally on an input.
REQ-015 Bit counter: $clog2(WIDTH)+1 bits; cleared on every state entry; increments by 1 on the counted edge, no wrap within a state.
REQ-016 IDLE: all outputs 0; csN=0 -> GET_ADDR next cycle; an SCLK edge pulse in the same cycle is ignored.
REQ-017 GET_ADDR: counts sclkPosEdge; on the cycle the count reaches WIDTH -> GOT_ADDR.
REQ-018 GOT_ADDR: one cycle, addrLatchEn=1; rwBit=1 -> READ_LOAD, else -> WRITE_GET.
REQ-019 READ_LOAD: one cycle, srParallelLoad=1, then READ_SHIFT.
REQ-020 READ_SHIFT: misoBufEn=1; counts sclkNegEdge; count reaches WIDTH -> DONE.
REQ-021 WRITE_GET: counts sclkPosEdge; count reaches WIDTH -> WRITE_STORE.
REQ-022 WRITE_STORE: one cycle, memWriteEn=1, then DONE.
REQ-023 DONE: all strobes 0, busy=1; stays until csN=1.
REQ-024 csN=1 in any non-IDLE state -> IDLE next cycle; counter cleared; a one-cycle strobe due that cycle is still issued but no later strobe.
REQ-025 Edge pulses are ignored in GOT_ADDR, READ_LOAD, WRITE_STORE, and DONE.
REQ-026 Simultaneous sclkPosEdge and sclkNegEdge: count only the edge relevant to the current state.
REQ-027 Each of addrLatchEn, srParallelLoad, and memWriteEn is asserted at most once per transaction, for exactly one clk.

Reset
REQ-028 resetN=0 asynchronously forces IDLE, counter=0, and all outputs 0, regardless of clk.
REQ-029 After resetN rises, the first transition requires a clk edge with csN=0; a transaction in progress at reset is abandoned with no write.

Structure
REQ-030 State encoding and the default WIDTH constant live in a shared package/include, spi_fsm_pkg.
REQ-031 The bit counter is one sub-module, bit_counter: clear, enable, count out, parameterised width.
REQ-032 Implementation is one state register plus next-state and output decode; no latches.

Verification
REQ-033 Write: csN low, 8 posedges with rwBit=0 at GOT_ADDR, 8 more posedges -> addrLatchEn one pulse, memWriteEn one pulse 1 cycle after the 16th posedge, then DONE.
REQ-034 Read: csN low, 8 posedges with rwBit=1 -> addrLatchEn pulse, srParallelLoad pulse on the next cycle, misoBufEn high until the 8th negedge, then DONE.
REQ-035 Abort: csN rises after 5 address posedges -> IDLE next cycle, busy=0, no strobes ever asserted.
REQ-036 Async reset asserted mid-WRITE_GET (count=3), with no clk edge -> all outputs 0 immediately; memWriteEn never asserts.
REQ-037 Edge pulses during DONE plus 3 extra posedges -> no strobes; csN high -> IDLE; a new transaction then completes normally.
REQ-038 csN low and sclkPosEdge in the same IDLE cycle -> that edge is not counted; 9 posedges are needed to reach GOT_ADDR.

Source files
------------

// File: rtl/spi_fsm_pkg.sv
// -----------------------------------------------------------------------------
// spi_fsm_pkg
// Shared definitions for the SPI slave control FSM:
//   - default bits-per-byte constant
//   - state encoding (legacy-compatible 3-bit localparams)
//   - packed control-output bundle and its Moore decode function
// -----------------------------------------------------------------------------
package spi_fsm_pkg;

    localparam int SPI_WIDTH_DEFAULT = 8;
    localparam int STATE_W           = 3;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_GET_ADDR    = 3'd1;
    localparam logic [2:0] ST_GOT_ADDR    = 3'd2;
    localparam logic [2:0] ST_READ_LOAD   = 3'd3;
    localparam logic [2:0] ST_READ_SHIFT  = 3'd4;
    localparam logic [2:0] ST_WRITE_GET   = 3'd5;
    localparam logic [2:0] ST_WRITE_STORE = 3'd6;
    localparam logic [2:0] ST_DONE        = 3'd7;

    typedef struct packed {
        logic busy;
        logic addr_latch_en;
        logic mem_write_en;
        logic sr_parallel_load;
        logic miso_buf_en;
    } spi_ctl_t;

    // Moore output decode: the control bundle is a pure function of state.
    function automatic spi_ctl_t decode_outputs(input logic [2:0] state);
        spi_ctl_t ctl;
        ctl                  = '0;
        ctl.busy             = (state != ST_IDLE);
        ctl.addr_latch_en    = (state == ST_GOT_ADDR);
        ctl.mem_write_en     = (state == ST_WRITE_STORE);
        ctl.sr_parallel_load = (state == ST_READ_LOAD);
        ctl.miso_buf_en      = (state == ST_READ_SHIFT);
        return ctl;
    endfunction

endpackage

// File: rtl/spi_fsm_bit_counter.sv
// -----------------------------------------------------------------------------
// bit_counter
// Saturating up-counter used to count SCLK edges within one FSM state.
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset (count -> 0)
//   i_clear  synchronous clear, has priority over i_en
//   i_en     increment by one this cycle
//   o_count  current count
// -----------------------------------------------------------------------------
module bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count register: clear wins, otherwise saturate instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/spi_fsm.sv
// -----------------------------------------------------------------------------
// spi_fsm
// Control FSM of an SPI slave: collects an address/RW byte, then either shifts
// a byte out (read) or collects a byte and strobes the memory write (write).
// Ports:
//   clk            system clock, rising edge
//   resetN         asynchronous active-low reset
//   csN            chip select, active-low, synchronous to clk
//   sclkPosEdge    one-clk pulse per SCLK rising edge
//   sclkNegEdge    one-clk pulse per SCLK falling edge
//   rwBit          R/W bit from the shift register (1 = read)
//   addrLatchEn    load address latch
//   memWriteEn     data memory write strobe
//   srParallelLoad shift register parallel load
//   misoBufEn      MISO tri-state enable
//   busy           high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module spi_fsm
    import spi_fsm_pkg::*;
#(
    parameter int WIDTH = SPI_WIDTH_DEFAULT
) (
    input  logic clk,
    input  logic resetN,
    input  logic csN,
    input  logic sclkPosEdge,
    input  logic sclkNegEdge,
    input  logic rwBit,
    output logic addrLatchEn,
    output logic memWriteEn,
    output logic srParallelLoad,
    output logic misoBufEn,
    output logic busy
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    // The edge that arrives while the count is WIDTH-1 is the WIDTH-th edge.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic [CNT_W-1:0]   w_count;
    logic               w_cnt_en;
    logic               w_cnt_clear;
    logic               w_last_edge;
    spi_ctl_t           r_ctl;

    // Select which SCLK edge (if any) the current state counts.
    always_comb begin
        w_cnt_en = 1'b0;
        case (r_state)
            ST_GET_ADDR,
            ST_WRITE_GET:  w_cnt_en = sclkPosEdge;
            ST_READ_SHIFT: w_cnt_en = sclkNegEdge;
            default:       w_cnt_en = 1'b0;
        endcase
    end

    assign w_last_edge = w_cnt_en && (w_count == LAST_CNT);

    // Next-state decode; deselect aborts from any non-idle state.
    always_comb begin
        w_next_state = r_state;
        if ((r_state != ST_IDLE) && csN) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!csN) begin
                        w_next_state = ST_GET_ADDR;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_GET_ADDR: begin
                    if (w_last_edge) begin
                        w_next_state = ST_GOT_ADDR;
                    end else begin
                        w_next_state = ST_GET_ADDR;
                    end
                end
                ST_GOT_ADDR: begin
                    if (rwBit) begin
                        w_next_state = ST_READ_LOAD;
                    end else begin
                        w_next_state = ST_WRITE_GET;
                    end
                end
                ST_READ_LOAD:   w_next_state = ST_READ_SHIFT;
                ST_READ_SHIFT: begin
                    if (w_last_edge) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_READ_SHIFT;
                    end
                end
                ST_WRITE_GET: begin
                    if (w_last_edge) begin
                        w_next_state = ST_WRITE_STORE;
                    end else begin
                        w_next_state = ST_WRITE_GET;
                    end
                end
                ST_WRITE_STORE: w_next_state = ST_DONE;
                ST_DONE:        w_next_state = ST_DONE;
                default:        w_next_state = ST_IDLE;
            endcase
        end
    end

    // Counter restarts on every state change, including re-entry to IDLE.
    assign w_cnt_clear = (w_next_state != r_state);

    bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .i_clk   (clk),
        .i_rst_n (resetN),
        .i_clear (w_cnt_clear),
        .i_en    (w_cnt_en),
        .o_count (w_count)
    );

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Output register: decoding the next state keeps outputs aligned with
    // r_state while presenting glitch-free flop outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_ctl <= '0;
        end else begin
            r_ctl <= decode_outputs(w_next_state);
        end
    end

    assign busy           = r_ctl.busy;
    assign addrLatchEn    = r_ctl.addr_latch_en;
    assign memWriteEn     = r_ctl.mem_write_en;
    assign srParallelLoad = r_ctl.sr_parallel_load;
    assign misoBufEn      = r_ctl.miso_buf_en;

endmodule

// File: tb/tb_spi_fsm.sv
// -----------------------------------------------------------------------------
// tb_spi_fsm
// Directed self-checking bench for spi_fsm. Output vector order in checks:
// {busy, addrLatchEn, memWriteEn, srParallelLoad, misoBufEn}.
// -----------------------------------------------------------------------------
module tb_spi_fsm;

    logic clk = 1'b0;
    logic resetN;
    logic csN;
    logic sclkPosEdge;
    logic sclkNegEdge;
    logic rwBit;
    logic addrLatchEn;
    logic memWriteEn;
    logic srParallelLoad;
    logic misoBufEn;
    logic busy;
    logic [4:0] w_out;

    int n_vec = 0;
    int n_err = 0;
    int n_ale = 0;
    int n_mwe = 0;
    int n_srl = 0;
    int s_ale;
    int s_mwe;
    int s_srl;

    localparam logic [4:0] O_IDLE  = 5'b00000;
    localparam logic [4:0] O_BUSY  = 5'b10000;
    localparam logic [4:0] O_ALE   = 5'b11000;
    localparam logic [4:0] O_MWE   = 5'b10100;
    localparam logic [4:0] O_SRL   = 5'b10010;
    localparam logic [4:0] O_MISO  = 5'b10001;

    spi_fsm #(.WIDTH(8)) dut (
        .clk            (clk),
        .resetN         (resetN),
        .csN            (csN),
        .sclkPosEdge    (sclkPosEdge),
        .sclkNegEdge    (sclkNegEdge),
        .rwBit          (rwBit),
        .addrLatchEn    (addrLatchEn),
        .memWriteEn     (memWriteEn),
        .srParallelLoad (srParallelLoad),
        .misoBufEn      (misoBufEn),
        .busy           (busy)
    );

    assign w_out = {busy, addrLatchEn, memWriteEn, srParallelLoad, misoBufEn};

    always #5 clk = ~clk;

    // Strobe-cycle counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (addrLatchEn)    n_ale <= n_ale + 1;
        if (memWriteEn)     n_mwe <= n_mwe + 1;
        if (srParallelLoad) n_srl <= n_srl + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic p, input logic n);
        sclkPosEdge = p;
        sclkNegEdge = n;
        tick();
        sclkPosEdge = 1'b0;
        sclkNegEdge = 1'b0;
    endtask

    task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        s_ale = n_ale;
        s_mwe = n_mwe;
        s_srl = n_srl;
    endtask

    initial begin
        resetN = 1'b1; csN = 1'b1; sclkPosEdge = 1'b0; sclkNegEdge = 1'b0; rwBit = 1'b0;
        #2 resetN = 1'b0;
        #1 check("reset_async", w_out, O_IDLE);
        tick(); tick();
        check("reset_held", w_out, O_IDLE);
        resetN = 1'b1;
        tick();
        check("idle_after_reset", w_out, O_IDLE);
        pulse(1'b1, 1'b1);
        check("idle_ignores_edges", w_out, O_IDLE);

        // ---- write transaction ----
        snap();
        rwBit = 1'b0;
        csN = 1'b0;
        tick();
        check("wr_get_addr", w_out, O_BUSY);
        repeat (7) pulse(1'b1, 1'b0);
        check("wr_addr_7", w_out, O_BUSY);
        pulse(1'b1, 1'b0);
        check("wr_got_addr", w_out, O_ALE);
        tick();
        check("wr_write_get", w_out, O_BUSY);
        repeat (7) pulse(1'b1, 1'b0);
        check("wr_data_7", w_out, O_BUSY);
        pulse(1'b1, 1'b0);
        check("wr_store", w_out, O_MWE);
        tick();
        check("wr_done", w_out, O_BUSY);
        tick();
        check("wr_done_hold", w_out, O_BUSY);
        csN = 1'b1;
        tick();
        check("wr_idle", w_out, O_IDLE);
        check_int("wr_ale_cnt", n_ale - s_ale, 1);
        check_int("wr_mwe_cnt", n_mwe - s_mwe, 1);
        check_int("wr_srl_cnt", n_srl - s_srl, 0);

        // ---- read transaction (simultaneous edges included) ----
        snap();
        rwBit = 1'b1;
        csN = 1'b0;
        tick();
        check("rd_get_addr", w_out, O_BUSY);
        pulse(1'b1, 1'b1);
        repeat (6) pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        check("rd_addr_negedge_ignored", w_out, O_BUSY);
        pulse(1'b1, 1'b0);
        check("rd_got_addr", w_out, O_ALE);
        tick();
        check("rd_load", w_out, O_SRL);
        tick();
        check("rd_shift", w_out, O_MISO);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        repeat (6) pulse(1'b0, 1'b1);
        check("rd_shift_7", w_out, O_MISO);
        pulse(1'b0, 1'b1);
        check("rd_done", w_out, O_BUSY);
        csN = 1'b1;
        tick();
        check("rd_idle", w_out, O_IDLE);
        check_int("rd_ale_cnt", n_ale - s_ale, 1);
        check_int("rd_srl_cnt", n_srl - s_srl, 1);
        check_int("rd_mwe_cnt", n_mwe - s_mwe, 0);

        // ---- abort after 5 address edges ----
        snap();
        csN = 1'b0;
        tick();
        repeat (5) pulse(1'b1, 1'b0);
        check("ab_mid_addr", w_out, O_BUSY);
        csN = 1'b1;
        tick();
        check("ab_idle", w_out, O_IDLE);
        tick();
        check_int("ab_strobes", (n_ale - s_ale) + (n_mwe - s_mwe) + (n_srl - s_srl), 0);

        // ---- async reset mid WRITE_GET ----
        snap();
        rwBit = 1'b0;
        csN = 1'b0;
        tick();
        repeat (8) pulse(1'b1, 1'b0);
        tick();
        repeat (3) pulse(1'b1, 1'b0);
        check("rs_write_get", w_out, O_BUSY);
        resetN = 1'b0;
        #1 check("rs_async_clear", w_out, O_IDLE);
        csN = 1'b1;
        tick(); tick();
        resetN = 1'b1;
        tick();
        check("rs_idle_cs_high", w_out, O_IDLE);
        check_int("rs_no_write", n_mwe - s_mwe, 0);

        // ---- edges in DONE, then a fresh transaction ----
        snap();
        rwBit = 1'b0;
        csN = 1'b0;
        tick();
        repeat (8) pulse(1'b1, 1'b0);
        tick();
        repeat (8) pulse(1'b1, 1'b0);
        tick();
        check("dn_done", w_out, O_BUSY);
        repeat (3) pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        check("dn_done_edges", w_out, O_BUSY);
        check_int("dn_ale_cnt", n_ale - s_ale, 1);
        check_int("dn_mwe_cnt", n_mwe - s_mwe, 1);
        csN = 1'b1;
        tick();
        check("dn_idle", w_out, O_IDLE);
        snap();
        rwBit = 1'b1;
        csN = 1'b0;
        tick();
        repeat (8) pulse(1'b1, 1'b0);
        check("dn2_got_addr", w_out, O_ALE);
        tick(); tick();
        repeat (8) pulse(1'b0, 1'b1);
        check("dn2_done", w_out, O_BUSY);
        csN = 1'b1;
        tick();
        check_int("dn2_srl_cnt", n_srl - s_srl, 1);

        // ---- csN fall and posedge in the same IDLE cycle ----
        snap();
        rwBit = 1'b0;
        csN = 1'b0;
        pulse(1'b1, 1'b0);
        check("id_first_edge", w_out, O_BUSY);
        repeat (7) pulse(1'b1, 1'b0);
        check("id_8_edges", w_out, O_BUSY);
        pulse(1'b1, 1'b0);
        check("id_9_edges", w_out, O_ALE);
        csN = 1'b1;
        tick();
        check("id_abort_idle", w_out, O_IDLE);
        tick();
        check_int("id_ale_cnt", n_ale - s_ale, 1);
        check_int("id_mwe_cnt", n_mwe - s_mwe, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
